// File: rtl/posit_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : posit_encoder_seq
//  Description : Multi-cycle posit(N,ES) encoder. Takes a decoded value
//                (sign, signed scale, fraction, zero/NaR flags) and produces
//                the packed posit using round-to-nearest-even. Values whose
//                magnitude is out of range saturate to maxpos or minpos.
//                Four-state handshake FSM: IDLE -> PACK -> RND -> DONE.
//
//  Ports       : clk        - clock, rising-edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - input fields valid
//                in_ready   - high only in IDLE
//                in_sign    - sign of the value
//                in_scale   - signed scale sc (value = 2^sc * 1.f)
//                in_frac    - fraction f, hidden one implied
//                in_zero    - value is zero
//                in_nar     - value is NaR (overrides in_zero)
//                out_valid  - result valid (DONE state)
//                out_ready  - consumer accepts result
//                out_posit  - encoded posit
//                out_sat    - result was clamped to maxpos/minpos
//
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_encoder_seq #(
    parameter int N  = 16,
    parameter int ES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [8:0]        in_scale,
    input  logic [N-ES-4:0]   in_frac,
    input  logic              in_zero,
    input  logic              in_nar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_posit,
    output logic              out_sat
);

    localparam int c_FRAC_W = N - ES - 3;
    // Wide enough for the longest in-range regime plus exponent and fraction.
    localparam int c_BODY_W = 2 * N - 2;
    localparam int c_PAD_W  = c_BODY_W - ES - c_FRAC_W;

    // Largest in-range |sc|: regime of N-2 identical bits.
    localparam logic signed [8:0] c_SC_MAX = 9'((N - 2) * (2 ** ES));
    localparam logic signed [8:0] c_SC_MIN = -c_SC_MAX;

    localparam logic [c_BODY_W-1:0] c_ONES   = {c_BODY_W{1'b1}};
    localparam logic [c_BODY_W-1:0] c_TOP    = {1'b1, {(c_BODY_W-1){1'b0}}};
    localparam logic [N-2:0]        c_MAXPOS = {(N-1){1'b1}};
    localparam logic [N-2:0]        c_MINPOS = (N-1)'(1);
    localparam logic [N-1:0]        c_NAR    = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_sign;
    logic signed [8:0]      r_scale;
    logic [c_FRAC_W-1:0]    r_frac;
    logic                   r_zero;
    logic                   r_nar;
    logic [c_BODY_W-1:0]    r_body;

    // ------------------------------------------------------------------
    // PACK: regime / exponent / fraction assembly
    // ------------------------------------------------------------------
    logic signed [8:0]      w_k;
    logic [8:0]             w_kp1;
    logic [8:0]             w_m;
    logic [8:0]             w_len;
    logic [c_BODY_W-1:0]    w_regime;
    logic [c_BODY_W-1:0]    w_tail;
    logic [c_BODY_W-1:0]    w_body;

    always_comb begin
        // Arithmetic shift gives floor(sc / 2^ES); low bits are sc mod 2^ES.
        w_k      = r_scale >>> ES;
        w_kp1    = 9'(w_k) + 9'd1;
        w_m      = 9'd0 - 9'(w_k);
        w_tail   = {r_scale[ES-1:0], r_frac, {c_PAD_W{1'b0}}};
        w_regime = '0;
        w_len    = '0;
        if (!w_k[8]) begin
            // k+1 ones followed by a terminating zero.
            w_regime = ~(c_ONES >> w_kp1);
            w_len    = 9'(w_k) + 9'd2;
        end else begin
            // -k zeros followed by a terminating one.
            w_regime = c_TOP >> w_m;
            w_len    = w_m + 9'd1;
        end
        w_body = w_regime | (w_tail >> w_len);
    end

    // ------------------------------------------------------------------
    // RND: round to nearest even, clamp, specials, sign
    // ------------------------------------------------------------------
    logic [N-2:0]           w_top;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_inc;
    logic [N-1:0]           w_sum;
    logic [N-2:0]           w_mag_body;
    logic                   w_mag_sat;
    logic [N-1:0]           w_mag;
    logic [N-1:0]           w_fin_posit;
    logic                   w_fin_sat;

    always_comb begin
        w_top    = r_body[c_BODY_W-1 -: N-1];
        w_guard  = r_body[c_BODY_W-N];
        w_sticky = |r_body[c_BODY_W-N-1:0];
        w_inc    = w_guard & (w_sticky | w_top[0]);
        w_sum    = {1'b0, w_top} + {{(N-1){1'b0}}, w_inc};

        w_mag_body = w_sum[N-2:0];
        w_mag_sat  = 1'b0;
        if ($signed(r_scale) > c_SC_MAX) begin
            w_mag_body = c_MAXPOS;
            w_mag_sat  = 1'b1;
        end else if ($signed(r_scale) < c_SC_MIN) begin
            w_mag_body = c_MINPOS;
            w_mag_sat  = 1'b1;
        end else if (w_sum[N-1]) begin
            // Carry out of maxpos must not wrap into the sign bit.
            w_mag_body = c_MAXPOS;
            w_mag_sat  = 1'b1;
        end else if (w_sum[N-2:0] == '0) begin
            // A nonzero value never encodes as zero.
            w_mag_body = c_MINPOS;
            w_mag_sat  = 1'b1;
        end

        w_mag = {1'b0, w_mag_body};
        if (r_nar) begin
            w_fin_posit = c_NAR;
            w_fin_sat   = 1'b0;
        end else if (r_zero) begin
            w_fin_posit = '0;
            w_fin_sat   = 1'b0;
        end else begin
            w_fin_posit = r_sign ? ({N{1'b0}} - w_mag) : w_mag;
            w_fin_sat   = w_mag_sat;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_scale   <= '0;
            r_frac    <= '0;
            r_zero    <= 1'b0;
            r_nar     <= 1'b0;
            r_body    <= '0;
            out_valid <= 1'b0;
            out_posit <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sign;
                        r_scale <= in_scale;
                        r_frac  <= in_frac;
                        r_zero  <= in_zero;
                        r_nar   <= in_nar;
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    r_body  <= w_body;
                    r_state <= S_RND;
                end
                S_RND: begin
                    out_posit <= w_fin_posit;
                    out_sat   <= w_fin_sat;
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_posit_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_encoder_seq
//  Description : Directed self-checking bench for posit_encoder_seq with
//                hand-computed posit(16,3) encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_encoder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_scale;
    logic [9:0]  in_frac;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_posit;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    posit_encoder_seq #(.N(16), .ES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one input at a negedge, then follow it through PACK/RND/DONE.
    task automatic run_vec(input string tag, input logic s, input int sc,
                           input logic [9:0] f, input logic z, input logic nr,
                           input logic [15:0] exp_p, input logic exp_s);
        @(negedge clk);
        check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_scale = 9'(sc);
        in_frac  = f;
        in_zero  = z;
        in_nar   = nr;
        @(negedge clk);                       // accept edge passed: PACK
        in_sign  = ~s;                        // changes outside IDLE are ignored
        in_scale = 9'(sc + 37);
        in_frac  = ~f;
        check({tag, "_v_pack"}, {15'd0, out_valid}, 16'd0);
        @(negedge clk);                       // RND
        check({tag, "_v_rnd"}, {15'd0, out_valid}, 16'd0);
        in_valid = 1'b0;
        @(negedge clk);                       // DONE
        check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        check({tag, "_posit"}, out_posit, exp_p);
        check({tag, "_sat"},   {15'd0, out_sat}, {15'd0, exp_s});
        out_ready = 1'b1;
        @(negedge clk);                       // back to IDLE
        out_ready = 1'b0;
        check({tag, "_release"}, {14'd0, in_ready, out_valid}, 16'b10);
    endtask

    logic [15:0] held;
    int          waited;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_scale  = '0;
        in_frac   = '0;
        in_zero   = 1'b0;
        in_nar    = 1'b0;
        out_ready = 1'b0;

        #3;
        check("rst_valid", {15'd0, out_valid}, 16'd0);
        check("rst_posit", out_posit, 16'h0000);
        check("rst_sat",   {15'd0, out_sat}, 16'd0);
        check("rst_ready", {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("one",      1'b0,    0, 10'h000, 1'b0, 1'b0, 16'h4000, 1'b0);
        run_vec("neg_one",  1'b1,    0, 10'h000, 1'b0, 1'b0, 16'hC000, 1'b0);
        run_vec("sc8",      1'b0,    8, 10'h000, 1'b0, 1'b0, 16'h6000, 1'b0);
        run_vec("half",     1'b0,   -1, 10'h000, 1'b0, 1'b0, 16'h3C00, 1'b0);
        run_vec("rnd_up",   1'b0,    8, 10'h3FF, 1'b0, 1'b0, 16'h6200, 1'b0);
        run_vec("rnd_tie",  1'b0,    8, 10'h001, 1'b0, 1'b0, 16'h6000, 1'b0);
        run_vec("rnd_stk",  1'b0,   16, 10'h007, 1'b0, 1'b0, 16'h7002, 1'b0);
        run_vec("neg_frac", 1'b1,    0, 10'h3FF, 1'b0, 1'b0, 16'hBC01, 1'b0);
        run_vec("small",    1'b0,   -9, 10'h200, 1'b0, 1'b0, 16'h1F00, 1'b0);
        run_vec("edge_hi",  1'b0,  112, 10'h000, 1'b0, 1'b0, 16'h7FFF, 1'b0);
        run_vec("edge_lo",  1'b0, -112, 10'h000, 1'b0, 1'b0, 16'h0001, 1'b0);
        run_vec("sat_hi",   1'b0,  200, 10'h000, 1'b0, 1'b0, 16'h7FFF, 1'b1);
        run_vec("sat_lo",   1'b0, -200, 10'h000, 1'b0, 1'b0, 16'h0001, 1'b1);
        run_vec("sat_neg",  1'b1,  200, 10'h000, 1'b0, 1'b0, 16'h8001, 1'b1);
        run_vec("zero",     1'b1,    5, 10'h155, 1'b1, 1'b0, 16'h0000, 1'b0);
        run_vec("nar",      1'b0,  200, 10'h000, 1'b1, 1'b1, 16'h8000, 1'b0);

        // Backpressure: hold out_ready low in DONE while poking in_valid.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_scale = 9'd8; in_frac = 10'h3FF;
        in_zero = 1'b0; in_nar = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid", {15'd0, out_valid}, 16'd1);
        check("bp_posit", out_posit, 16'h6200);
        held = out_posit;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_scale = 9'(i * 50);
            in_sign  = 1'b1;
            @(negedge clk);
            check("bp_hold",  out_posit, 16'h6200);
            check("bp_ready", {14'd0, in_ready, out_valid}, 16'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", {14'd0, in_ready, out_valid}, 16'b10);
        check("bp_held_val", held, 16'h6200);

        // Reset while the operation sits in RND.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_scale = 9'd0; in_frac = 10'h000;
        @(negedge clk);                       // PACK
        in_valid = 1'b0;
        @(negedge clk);                       // RND
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        check("mid_rst_posit", out_posit, 16'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        waited    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) waited++;
        end
        out_ready = 1'b0;
        check("mid_rst_no_out", 16'(waited), 16'd0);
        run_vec("after_rst", 1'b0, -1, 10'h000, 1'b0, 1'b0, 16'h3C00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
